// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter: shares one pipelined-read main memory between I-cache
// fills, D-cache fills and D-side write-through word writes. A fill reads one
// aligned block as back-to-back word reads. The returned words go to the cache
// that owns the fill.
module mem_fill_arbiter #(
    parameter  int AWIDTH        = 16,
    parameter  int DWIDTH        = 16,
    parameter  int BLOCK_WORDS   = 8,
    parameter  int WR_STREAK_MAX = 4,
    localparam int W             = $clog2(BLOCK_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [AWIDTH-1:0] i_addr,
    input  logic              d_req,
    input  logic [AWIDTH-1:0] d_addr,
    input  logic              d_wr_req,
    input  logic [AWIDTH-1:0] d_wr_addr,
    input  logic [DWIDTH-1:0] d_wr_data,
    output logic              d_wr_ack,
    output logic              i_fill_we,
    output logic              d_fill_we,
    output logic [DWIDTH-1:0] fill_data,
    output logic [W-1:0]      fill_word,
    output logic              i_done,
    output logic              d_done,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_data_in,
    input  logic [DWIDTH-1:0] mem_data_out,
    input  logic              mem_data_valid,
    input  logic [AWIDTH-1:0] mem_addr_out
);

    localparam int CW = W + 1;
    localparam int SW = $clog2(WR_STREAK_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL_I, S_FILL_D} state_t;

    state_t            r_state;
    logic [AWIDTH-1:0] r_base;
    logic [CW-1:0]     r_issue;
    logic [CW-1:0]     r_recv;
    logic [SW-1:0]     r_streak;
    logic              r_last_d;
    logic              r_i_done;
    logic              r_d_done;

    logic              w_idle;
    logic              w_i_elig;
    logic              w_d_elig;
    logic              w_pend;
    logic              w_wr_grant;
    logic              w_fill_grant;
    logic              w_pick_d;
    logic [AWIDTH-1:0] w_grant_addr;
    logic              w_issuing;
    logic              w_rx;
    logic              w_rx_last;
    logic              w_unused;

    // A requester finishing this cycle is still holding its request; do not regrant it.
    assign w_idle       = (r_state == S_IDLE);
    assign w_i_elig     = i_req & ~r_i_done;
    assign w_d_elig     = d_req & ~r_d_done;
    assign w_pend       = w_i_elig | w_d_elig;
    assign w_wr_grant   = w_idle & d_wr_req & ((r_streak < SW'(WR_STREAK_MAX)) | ~w_pend);
    assign w_fill_grant = w_idle & ~w_wr_grant & w_pend;
    assign w_pick_d     = w_d_elig & (~w_i_elig | ~r_last_d);
    assign w_grant_addr = w_pick_d ? d_addr : i_addr;
    assign w_issuing    = ~w_idle & (r_issue < CW'(BLOCK_WORDS));
    assign w_rx         = ~w_idle & mem_data_valid;
    assign w_rx_last    = w_rx & (r_recv == CW'(BLOCK_WORDS - 1));
    assign i_done       = r_i_done;
    assign d_done       = r_d_done;

    // The low address bits are dropped because the block is aligned and the word index comes from the address tag.
    assign w_unused = ^{mem_addr_out[AWIDTH-1:W+1], mem_addr_out[0], d_wr_addr[0],
                        i_addr[W:0], d_addr[W:0]};

    // Memory command mux and return routing. Only the write path and the return path are combinational.
    always_comb begin
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        d_wr_ack    = 1'b0;
        i_fill_we   = 1'b0;
        d_fill_we   = 1'b0;
        fill_data   = '0;
        fill_word   = '0;
        if (w_wr_grant) begin
            mem_enable  = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = {d_wr_addr[AWIDTH-1:1], 1'b0};
            mem_data_in = d_wr_data;
            d_wr_ack    = 1'b1;
        end else if (w_issuing) begin
            mem_enable  = 1'b1;
            mem_addr    = r_base + AWIDTH'({r_issue, 1'b0});
        end
        if (w_rx) begin
            i_fill_we = (r_state == S_FILL_I);
            d_fill_we = (r_state == S_FILL_D);
            fill_data = mem_data_out;
            fill_word = mem_addr_out[W:1];
        end
    end

    // Grant/fill sequencer. The fill ends when the last word returns, so any read latency works.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_base   <= '0;
            r_issue  <= '0;
            r_recv   <= '0;
            r_streak <= '0;
            r_last_d <= 1'b0;
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
        end else begin
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_wr_grant) begin
                        if (r_streak != SW'(WR_STREAK_MAX))
                            r_streak <= r_streak + 1'b1;
                    end else if (w_fill_grant) begin
                        r_state  <= w_pick_d ? S_FILL_D : S_FILL_I;
                        r_base   <= {w_grant_addr[AWIDTH-1:W+1], {(W+1){1'b0}}};
                        r_issue  <= '0;
                        r_recv   <= '0;
                        r_streak <= '0;
                        r_last_d <= w_pick_d;
                    end else begin
                        r_streak <= '0;
                    end
                end
                S_FILL_I, S_FILL_D: begin
                    if (w_issuing)
                        r_issue <= r_issue + 1'b1;
                    if (w_rx)
                        r_recv <= r_recv + 1'b1;
                    if (w_rx_last) begin
                        r_state  <= S_IDLE;
                        r_i_done <= (r_state == S_FILL_I);
                        r_d_done <= (r_state == S_FILL_D);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Bench for mem_fill_arbiter. A pipelined memory model has a selectable read
// latency. A per-cycle transaction model keeps the outstanding fill as a queue
// of block addresses. It checks every memory command, ack, fill word and done
// pulse. Random traffic runs across several latencies and includes random
// resets, alongside directed fill and tie cases.
module tb_mem_fill_arbiter;

    localparam int BW   = 8;
    localparam int W    = 3;
    localparam int WMAX = 4;

    logic        clk, rst;
    logic        i_req, d_req, d_wr_req;
    logic [15:0] i_addr, d_addr, d_wr_addr, d_wr_data;
    logic        d_wr_ack, i_fill_we, d_fill_we, i_done, d_done;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_data_in;
    logic [15:0] mem_data_out, mem_addr_out;
    logic        mem_data_valid;

    mem_fill_arbiter #(.AWIDTH(16), .DWIDTH(16), .BLOCK_WORDS(BW), .WR_STREAK_MAX(WMAX)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_addr(d_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_ack(d_wr_ack),
        .i_fill_we(i_fill_we), .d_fill_we(d_fill_we), .fill_data(fill_data), .fill_word(fill_word),
        .i_done(i_done), .d_done(d_done),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid), .mem_addr_out(mem_addr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- memory model: single-cycle write, in-order reads after lat cycles
    typedef struct { int due; logic [15:0] a; } rd_t;
    rd_t         mq[$];
    logic [15:0] mem_arr [logic [15:0]];
    int          lat = 4;
    int          cyc = 0;

    function automatic logic [15:0] rdval(input logic [15:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return a ^ 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        rd_t r;
        if (rst) begin
            mq.delete();
            mem_data_valid <= 1'b0;
            mem_data_out   <= '0;
            mem_addr_out   <= '0;
        end else begin
            if (mem_enable && mem_wr) mem_arr[mem_addr] = mem_data_in;
            if (mem_enable && !mem_wr) begin
                r.due = cyc + lat;
                r.a   = mem_addr;
                mq.push_back(r);
            end
            if (mq.size() > 0 && mq[0].due == cyc + 1) begin
                r = mq.pop_front();
                mem_data_valid <= 1'b1;
                mem_addr_out   <= r.a;
                mem_data_out   <= rdval(r.a);
            end else begin
                mem_data_valid <= 1'b0;
            end
        end
        cyc = cyc + 1;
    end

    // ---------------- reference model, evaluated mid-cycle
    int          m_own = 0;   // 0 none, 1 I, 2 D
    int          m_last = 1;  // last served: 1 I, 2 D
    int          m_got = 0;
    int          m_streak = 0;
    bit          m_di = 0, m_dd = 0;
    logic [15:0] m_rdq[$];

    always @(negedge clk) begin
        bit ei, ed, wr;
        logic [15:0] base, a;
        if (rst) begin
            m_own = 0; m_last = 1; m_got = 0; m_streak = 0; m_di = 0; m_dd = 0;
            m_rdq.delete();
        end else if (m_own == 0) begin
            ei = i_req && !m_di;
            ed = d_req && !m_dd;
            wr = d_wr_req && (m_streak < WMAX || !(ei || ed));
            chk("i_done", i_done, m_di);
            chk("d_done", d_done, m_dd);
            chk("idle_ifwe", i_fill_we, 0);
            chk("idle_dfwe", d_fill_we, 0);
            chk("idle_fdata", fill_data, 0);
            chk("idle_fword", fill_word, 0);
            chk("idle_en", mem_enable, wr);
            chk("idle_wr", mem_wr, wr);
            chk("idle_ack", d_wr_ack, wr);
            if (wr) begin
                chk("wr_addr", mem_addr, d_wr_addr & 16'hFFFE);
                chk("wr_data", mem_data_in, d_wr_data);
                if (m_streak < WMAX) m_streak++;
            end else begin
                chk("idle_addr", mem_addr, 0);
                chk("idle_wdata", mem_data_in, 0);
                if (ei || ed) begin
                    m_own  = (ei && ed) ? ((m_last == 1) ? 2 : 1) : (ei ? 1 : 2);
                    m_last = m_own;
                    base   = ((m_own == 1) ? i_addr : d_addr) & ~16'(2 * BW - 1);
                    for (int n = 0; n < BW; n++) m_rdq.push_back(base + 16'(2 * n));
                    m_got = 0;
                end
                m_streak = 0;
            end
            m_di = 0;
            m_dd = 0;
        end else begin
            chk("fill_ack", d_wr_ack, 0);
            chk("fill_wr", mem_wr, 0);
            chk("fill_idone", i_done, 0);
            chk("fill_ddone", d_done, 0);
            chk("fill_en", mem_enable, m_rdq.size() > 0);
            if (m_rdq.size() > 0) begin
                a = m_rdq.pop_front();
                chk("rd_addr", mem_addr, a);
            end
            chk("ifwe", i_fill_we, mem_data_valid && m_own == 1);
            chk("dfwe", d_fill_we, mem_data_valid && m_own == 2);
            if (mem_data_valid) begin
                chk("fill_data", fill_data, mem_data_out);
                chk("fill_word", fill_word, mem_addr_out[W:1]);
                chk("fill_order", fill_word, m_got);
                m_got++;
                if (m_got == BW) begin
                    if (m_own == 1) m_di = 1; else m_dd = 1;
                    m_own = 0;
                end
            end
        end
    end

    // ---------------- stimulus
    task automatic do_reset();
        i_req = 0; d_req = 0; d_wr_req = 0;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    initial begin
        int  k;
        bit  i_drop, d_drop;
        int  lats[5] = '{1, 7, 2, 5, 3};
        rst = 1; i_req = 0; d_req = 0; d_wr_req = 0;
        i_addr = 0; d_addr = 0; d_wr_addr = 0; d_wr_data = 0;
        @(posedge clk); #1;
        do_reset();

        // single I fill, L=4: done in cycle 13 counting the request cycle as 0
        lat = 4;
        do_reset();
        @(posedge clk); #1;
        i_req = 1; i_addr = 16'h1236;
        k = 0;
        while (k < 40 && !i_done) begin @(posedge clk); #1; k++; end
        chk("i_done_cycle", k, 13);
        @(posedge clk); #1;
        i_req = 0;
        chk("i_done_once", i_done, 0);

        // tie after reset goes to D, then I is granted in the D done cycle
        do_reset();
        @(posedge clk); #1;
        i_req = 1; d_req = 1; i_addr = 16'h2222; d_addr = 16'h4448;
        k = 0;
        while (k < 60 && !(i_done || d_done)) begin @(posedge clk); #1; k++; end
        chk("tie_d_first", d_done, 1);
        chk("tie_i_later", i_done, 0);
        @(posedge clk); #1;
        d_req = 0;
        k = 0;
        while (k < 60 && !i_done) begin @(posedge clk); #1; k++; end
        chk("tie_i_done", i_done, 1);
        chk("tie_i_cycle", k, 12);
        @(posedge clk); #1;
        i_req = 0;

        // random traffic at several latencies
        foreach (lats[p]) begin
            lat = lats[p];
            do_reset();
            i_drop = 0; d_drop = 0;
            for (int c = 0; c < 1500; c++) begin
                @(posedge clk); #1;
                if (rst) begin
                    rst = 0;
                    continue;
                end
                if ($urandom_range(399) == 0) begin
                    rst = 1; i_req = 0; d_req = 0; d_wr_req = 0;
                    i_drop = 0; d_drop = 0;
                    continue;
                end
                if (i_req && i_drop) i_req = 0;
                else if (!i_req && $urandom_range(2) == 0) begin i_req = 1; i_addr = 16'($urandom); end
                if (d_req && d_drop) d_req = 0;
                else if (!d_req && $urandom_range(2) == 0) begin d_req = 1; d_addr = 16'($urandom); end
                i_drop = i_done;
                d_drop = d_done;
                d_wr_req  = ($urandom_range(2) != 0);
                d_wr_addr = 16'($urandom);
                d_wr_data = 16'($urandom);
            end
        end

        i_req = 0; d_req = 0; d_wr_req = 0;
        repeat (20) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mem_fill_arbiter.md
# mem_fill_arbiter

Arbiter and block-fill sequencer placed in front of the shared 16-bit, byte-addressed, multi-cycle-read main memory (`memory4c`-class interface: single-cycle write, pipelined read with `data_valid`/`addr_out`). It serves three requesters:

- I-cache miss fills.
- D-cache miss fills.
- D-side write-through word writes.

A fill streams one aligned cache block as BLOCK_WORDS back-to-back reads and routes the returned words to the owning cache.

## Interface

Parameters:

- AWIDTH, 16, byte address width.
- DWIDTH, 16, data word width.
- BLOCK_WORDS, 8, words per cache block; power of two, at least 2. Block size = 2*BLOCK_WORDS bytes.
- WR_STREAK_MAX, 4, maximum consecutive writes granted while a fill is pending.

Ports (W = log2(BLOCK_WORDS)):

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `i_req`  in  1  I-cache fill request; held until `i_done`.
- `i_addr`  in  AWIDTH  I-cache miss address.
- `d_req`  in  1  D-cache fill request; held until `d_done`.
- `d_addr`  in  AWIDTH  D-cache miss address.
- `d_wr_req`  in  1  D-side word write request.
- `d_wr_addr`  in  AWIDTH  write address; bit 0 is ignored.
- `d_wr_data`  in  DWIDTH  write data.
- `d_wr_ack`  out  1  write accepted this cycle.
- `i_fill_we`, `d_fill_we`  out  1 each  returned fill word valid for the I-cache / D-cache.
- `fill_data`  out  DWIDTH  returned word.
- `fill_word`  out  W  word index of the returned word within the block.
- `i_done`, `d_done`  out  1 each  one-cycle pulse when the fill completes.
- `mem_enable`, `mem_wr`  out  1 each  memory command.
- `mem_addr`  out  AWIDTH  memory address.
- `mem_data_in`  out  DWIDTH  memory write data.
- `mem_data_out`  in  DWIDTH  memory read data.
- `mem_data_valid`  in  1  memory read data valid.
- `mem_addr_out`  in  AWIDTH  address tag of the returned read data.

## Operation

State machine has three states: IDLE, FILL_I, FILL_D.

Grant in IDLE, evaluated every cycle, highest priority first:

1. Write. Applies when `d_wr_req` is high and the write streak is below WR_STREAK_MAX (or no fill is pending).
   - Combinationally drive `mem_enable=1`, `mem_wr=1`, `mem_addr=d_wr_addr`, `mem_data_in=d_wr_data`, `d_wr_ack=1`.
   - Stay in IDLE. Increment the streak counter, saturating.
2. Fill. Applies when `i_req` and/or `d_req` is high.
   - If both are high, grant the requester not served by the previous fill (round-robin).
   - Latch `base = {addr[AWIDTH-1:log2(2*BLOCK_WORDS)], 0}`. Move to FILL_I or FILL_D.
   - Clear the streak counter. Record the owner as last-served.
- The streak counter also clears on any IDLE cycle with no write granted.
- A requester whose `*_done` is high in the current cycle is not eligible for a grant in that cycle.

FILL_x behaviour:

- Issue phase: for issue counter `n = 0 .. BLOCK_WORDS-1`, drive `mem_enable=1`, `mem_wr=0`, `mem_addr = base + 2n`, one read per cycle with no gaps.
- After the issue phase: drive `mem_enable=0`. Writes are not granted during FILL (`d_wr_ack=0`).
- Return path:
  - On each `mem_data_valid`, drive `x_fill_we=1`, `fill_data=mem_data_out`, `fill_word=mem_addr_out[W:1]`.
  - Increment the receive counter.
- Completion: when the receive counter reaches BLOCK_WORDS, at the next edge go to IDLE with `x_done=1` for exactly that one IDLE cycle.
- The block must be correct for any memory read latency of 1 or more cycles. Completion is driven only by valid counting, never by a fixed delay.

Output defaults and guards:

- Idle values: `mem_enable`, `mem_wr`, `mem_addr`, `mem_data_in`, `*_fill_we`, `fill_data`, `fill_word`, `*_done`, `d_wr_ack` are all 0.
- `mem_data_valid` arriving in IDLE is ignored: no `*_fill_we`.

Reset:

- State returns to IDLE; all counters clear; last-served = I, so the first tie goes to D.
- All outputs are 0 in the cycle after the reset edge.
- Reset mid-fill abandons the fill. No `*_done` is pulsed, and in-flight returns are ignored because the memory pipeline shares `rst`.

## Timing

Fill timing (BLOCK_WORDS=8, latency L=4), with the request seen in IDLE at cycle 0:

- FILL state from cycle 1; reads issued in cycles 1–8.
- Fill words arrive in cycles 1+L .. 8+L, i.e. 5–12.
- `x_done` pulses and the state is IDLE in cycle 13. A new grant may occur in cycle 13.

Write timing:

- `d_wr_ack` is in the same cycle as `d_wr_req` when granted. Back-to-back writes sustain 1 per cycle.
- Combinational paths: `d_wr_req`/`d_wr_addr`/`d_wr_data` to the `mem_*` outputs and `d_wr_ack` (IDLE only); `mem_data_valid`/`mem_data_out` to the fill outputs.

## Test plan

- Single I fill: reset, `i_addr=0x1236` -> reads at 0x1230..0x123E in cycles 1–8; `i_fill_we` cycles 5–12 with `fill_word` 0..7; `i_done` in cycle 13 only.
- Simultaneous `i_req`/`d_req` after reset -> D served first (base from `d_addr`), then I granted in the D-done cycle; no I fill outputs during the D fill.
- Write during fill: `d_wr_req` asserted in cycle 3 of a fill -> `d_wr_ack=0` until the IDLE/done cycle; then the write is issued with `mem_wr=1` and the correct addr/data.
- Write streak: continuous `d_wr_req` with `i_req` pending -> exactly 4 acks, then I fill granted; writes resume after `i_done`.
- Variable latency: memory model with L=1 and L=7 -> 8 fill words each, `done` one cycle after the 8th valid.
- Reset mid-fill: `rst` in cycle 6 of a fill -> no `*_fill_we`/`*_done` afterwards, all outputs 0; next `i_req` completes a full fill normally.
